ecc_mem_reader: RTL and testbench

- Read-side counterpart of the BCH encoder memory writer.
- On a start pulse it fetches the stored ECC bytes from the synchronous on-chip memory (syn_mem) and reassembles them into one parity word.
- The parity word feeds the BCH decoder during regeneration mode.
- Sequencing comes from the controller, through the same en/start/ready style as the encoder and decoder wrappers.

---
 rtl/ecc_mem_reader_if.sv | 26 ++
 rtl/ecc_mem_reader.sv | 123 ++++++++++++
 tb/tb_ecc_mem_reader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_mem_reader_if.sv
// Bus bundle between the controller/syn_mem side and the ECC reader.
// Carries the en/start/ready handshake, memory read port and parity result.
interface ecc_mem_reader_if #(
    parameter int ECC_BITS       = 15,
    parameter int MEM_ADDR_WIDTH = 6,
    parameter int MEM_DATA_WIDTH = 8
);
    logic                      I_en;
    logic                      I_start;
    logic [MEM_DATA_WIDTH-1:0] I_mem_data;
    logic [MEM_ADDR_WIDTH-1:0] O_mem_addr;
    logic                      O_mem_req;
    logic [ECC_BITS-1:0]       O_ecc;
    logic                      O_valid;
    logic                      O_ready;

    modport slave (
        input  I_en, I_start, I_mem_data,
        output O_mem_addr, O_mem_req, O_ecc, O_valid, O_ready
    );

    modport master (
        output I_en, I_start, I_mem_data,
        input  O_mem_addr, O_mem_req, O_ecc, O_valid, O_ready
    );
endinterface

// File: rtl/ecc_mem_reader.sv
// Fetches stored BCH parity bytes from syn_mem and reassembles the parity word.
// Word 0 lands in the LSBs; padding bits of the last word are dropped.
module ecc_mem_reader #(
    parameter int ECC_BITS        = 15,
    parameter int MEM_ADDR_WIDTH  = 6,
    parameter int MEM_DATA_WIDTH  = 8,
    parameter int MEM_ECC_ST_ADDR = 48
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    ecc_mem_reader_if.slave    bus
);
    localparam int NB = (ECC_BITS + MEM_DATA_WIDTH - 1) / MEM_DATA_WIDTH;
    localparam int CW = $clog2(NB + 2);
    localparam logic [MEM_ADDR_WIDTH-1:0] L_ST = MEM_ADDR_WIDTH'(MEM_ECC_ST_ADDR);
    localparam logic [CW-1:0] L_ISSUE = CW'(NB - 1);
    localparam logic [CW-1:0] L_LAST  = CW'(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                    r_state, w_state;
    logic [MEM_ADDR_WIDTH-1:0] r_addr,  w_addr;
    logic                      r_req,   w_req;
    logic [ECC_BITS-1:0]       r_ecc,   w_ecc;
    logic                      r_valid, w_valid;
    logic                      r_ready, w_ready;
    logic [CW-1:0]             r_cnt,   w_cnt;
    logic [ECC_BITS-1:0]       w_cap;

    // r_cnt holds the edge index of the previous edge; data for word r_cnt-1
    // is on I_mem_data now (one-cycle syn_mem latency after address issue).
    always_comb begin
        w_cap = r_ecc;
        for (int i = 0; i < ECC_BITS; i++) begin
            if ((i / MEM_DATA_WIDTH) == (int'(r_cnt) - 1))
                w_cap[i] = bus.I_mem_data[i % MEM_DATA_WIDTH];
        end
    end

    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_req   = r_req;
        w_ecc   = r_ecc;
        w_valid = r_valid;
        w_ready = r_ready;
        w_cnt   = r_cnt;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.I_start) begin
                    w_state = S_FETCH;
                    w_ecc   = '0;
                    w_valid = 1'b0;
                    w_addr  = L_ST;
                    w_req   = 1'b1;
                    w_ready = 1'b0;
                    w_cnt   = '0;
                end
            end
            S_FETCH: begin
                w_cnt = r_cnt + CW'(1);
                if (r_cnt < L_ISSUE)
                    w_addr = r_addr + MEM_ADDR_WIDTH'(1);
                if (r_cnt != '0)
                    w_ecc = w_cap;
                if (r_cnt == L_ISSUE)
                    w_state = S_DRAIN;
            end
            S_DRAIN: begin
                w_cnt = r_cnt + CW'(1);
                w_ecc = w_cap;
                if (r_cnt == L_LAST) begin
                    w_state = S_DONE;
                    w_valid = 1'b1;
                    w_req   = 1'b0;
                    w_ready = 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
        // Disable aborts from any state and wipes the partial result.
        if (!bus.I_en) begin
            w_state = S_IDLE;
            w_addr  = L_ST;
            w_req   = 1'b0;
            w_ecc   = '0;
            w_valid = 1'b0;
            w_ready = 1'b1;
            w_cnt   = '0;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= L_ST;
            r_req   <= 1'b0;
            r_ecc   <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_req   <= w_req;
            r_ecc   <= w_ecc;
            r_valid <= w_valid;
            r_ready <= w_ready;
            r_cnt   <= w_cnt;
        end
    end

    assign bus.O_mem_addr = r_addr;
    assign bus.O_mem_req  = r_req;
    assign bus.O_ecc      = r_ecc;
    assign bus.O_valid    = r_valid;
    assign bus.O_ready    = r_ready;
endmodule

// File: tb/tb_ecc_mem_reader.sv
// Bench for ecc_mem_reader: three parameter sets, each with its own syn_mem model.
// Expected parity words come from plain arithmetic on the stored bytes.
module tb_ecc_mem_reader;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ecc_mem_reader_if #(.ECC_BITS(15), .MEM_ADDR_WIDTH(6), .MEM_DATA_WIDTH(8)) a ();
    ecc_mem_reader_if #(.ECC_BITS(16), .MEM_ADDR_WIDTH(6), .MEM_DATA_WIDTH(8)) b ();
    ecc_mem_reader_if #(.ECC_BITS(20), .MEM_ADDR_WIDTH(6), .MEM_DATA_WIDTH(8)) c ();

    ecc_mem_reader #(.ECC_BITS(15), .MEM_ADDR_WIDTH(6), .MEM_DATA_WIDTH(8),
                     .MEM_ECC_ST_ADDR(48)) ua (.I_clk(clk), .I_rst_n(rst_n), .bus(a));
    ecc_mem_reader #(.ECC_BITS(16), .MEM_ADDR_WIDTH(6), .MEM_DATA_WIDTH(8),
                     .MEM_ECC_ST_ADDR(40)) ub (.I_clk(clk), .I_rst_n(rst_n), .bus(b));
    ecc_mem_reader #(.ECC_BITS(20), .MEM_ADDR_WIDTH(6), .MEM_DATA_WIDTH(8),
                     .MEM_ECC_ST_ADDR(48)) uc (.I_clk(clk), .I_rst_n(rst_n), .bus(c));

    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];
    logic [7:0] mem_c [64];

    always @(posedge clk) begin
        a.I_mem_data <= mem_a[a.O_mem_addr];
        b.I_mem_data <= mem_b[b.O_mem_addr];
        c.I_mem_data <= mem_c[c.O_mem_addr];
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op_a(input logic [7:0] w0, input logic [7:0] w1, input int exp);
        mem_a[48] = w0;
        mem_a[49] = w1;
        a.I_start = 1'b1;
        step();
        chk("a_addr_e0", 32'(a.O_mem_addr), 48);
        chk("a_req_e0", 32'(a.O_mem_req), 1);
        chk("a_rdy_e0", 32'(a.O_ready), 0);
        chk("a_val_e0", 32'(a.O_valid), 0);
        a.I_start = 1'b0;
        step();
        chk("a_addr_e1", 32'(a.O_mem_addr), 49);
        chk("a_rdy_e1", 32'(a.O_ready), 0);
        chk("a_val_e1", 32'(a.O_valid), 0);
        step();
        chk("a_addr_e2", 32'(a.O_mem_addr), 49);
        chk("a_req_e2", 32'(a.O_mem_req), 1);
        chk("a_val_e2", 32'(a.O_valid), 0);
        step();
        chk("a_val_e3", 32'(a.O_valid), 1);
        chk("a_ecc_e3", 32'(a.O_ecc), 32'(exp));
        chk("a_req_e3", 32'(a.O_mem_req), 0);
        chk("a_rdy_e3", 32'(a.O_ready), 1);
    endtask

    task automatic op_c(input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input int exp);
        mem_c[48] = w0;
        mem_c[49] = w1;
        mem_c[50] = w2;
        c.I_start = 1'b1;
        step();
        chk("c_rdy_e0", 32'(c.O_ready), 0);
        c.I_start = 1'b0;
        step();
        step();
        chk("c_addr_e2", 32'(c.O_mem_addr), 50);
        step();
        chk("c_addr_e3", 32'(c.O_mem_addr), 50);
        chk("c_val_e3", 32'(c.O_valid), 0);
        step();
        chk("c_val_e4", 32'(c.O_valid), 1);
        chk("c_ecc_e4", 32'(c.O_ecc), 32'(exp));
        chk("c_rdy_e4", 32'(c.O_ready), 1);
    endtask

    typedef struct {
        logic [7:0] w0;
        logic [7:0] w1;
        int         ecc;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{8'hA5, 8'hBC, 'h3CA5};
        tbl[1] = '{8'hFF, 8'hFF, 'h7FFF};
        tbl[2] = '{8'h00, 8'h80, 'h0000};
        tbl[3] = '{8'h01, 8'h7F, 'h7F01};
        tbl[4] = '{8'h5A, 8'hC3, 'h435A};
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
            mem_c[i] = 8'h00;
        end
        rst_n = 1'b0;
        a.I_en = 1'b1; a.I_start = 1'b0;
        b.I_en = 1'b1; b.I_start = 1'b0;
        c.I_en = 1'b1; c.I_start = 1'b0;
        step();
        step();
        chk("rst_addr", 32'(a.O_mem_addr), 48);
        chk("rst_req", 32'(a.O_mem_req), 0);
        chk("rst_ecc", 32'(a.O_ecc), 0);
        chk("rst_val", 32'(a.O_valid), 0);
        chk("rst_rdy", 32'(a.O_ready), 1);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) op_a(tbl[i].w0, tbl[i].w1, tbl[i].ecc);

        // result holds in DONE
        step();
        step();
        chk("hold_val", 32'(a.O_valid), 1);
        chk("hold_ecc", 32'(a.O_ecc), 'h435A);

        for (int i = 0; i < 12; i++) begin
            logic [7:0] w0, w1;
            w0 = 8'($urandom);
            w1 = 8'($urandom);
            op_a(w0, w1, (int'(w1) * 256 + int'(w0)) % (1 << 15));
        end

        // start held high for 10 edges: back-to-back ops, one read each
        mem_a[48] = 8'hA5;
        mem_a[49] = 8'hBC;
        a.I_start = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step();
            chk("bb_val", 32'(a.O_valid), 32'((e % 4) == 3));
            chk("bb_rdy", 32'(a.O_ready), 32'((e % 4) == 3));
            chk("bb_addr", 32'(a.O_mem_addr), ((e % 4) == 0) ? 48 : 49);
            if ((e % 4) == 3) chk("bb_ecc", 32'(a.O_ecc), 'h3CA5);
            if (e == 9) a.I_start = 1'b0;
        end

        // disable from DONE clears the held result
        a.I_en = 1'b0;
        step();
        chk("en_done_ecc", 32'(a.O_ecc), 0);
        chk("en_done_val", 32'(a.O_valid), 0);
        chk("en_done_rdy", 32'(a.O_ready), 1);
        a.I_en = 1'b1;

        // disable mid-fetch
        a.I_start = 1'b1;
        step();
        a.I_start = 1'b0;
        step();
        a.I_en = 1'b0;
        step();
        chk("en_mid_val", 32'(a.O_valid), 0);
        chk("en_mid_ecc", 32'(a.O_ecc), 0);
        chk("en_mid_addr", 32'(a.O_mem_addr), 48);
        chk("en_mid_req", 32'(a.O_mem_req), 0);
        chk("en_mid_rdy", 32'(a.O_ready), 1);
        a.I_en = 1'b1;
        step();
        step();
        step();
        chk("en_late_val", 32'(a.O_valid), 0);
        chk("en_late_ecc", 32'(a.O_ecc), 0);

        // async reset during DRAIN
        a.I_start = 1'b1;
        step();
        a.I_start = 1'b0;
        step();
        step();
        chk("pre_rst_ecc", 32'(a.O_ecc), 'hA5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_addr", 32'(a.O_mem_addr), 48);
        chk("arst_req", 32'(a.O_mem_req), 0);
        chk("arst_ecc", 32'(a.O_ecc), 0);
        chk("arst_val", 32'(a.O_valid), 0);
        chk("arst_rdy", 32'(a.O_ready), 1);
        #1 rst_n = 1'b1;
        step();
        op_a(8'h3C, 8'h96, 'h163C);

        // 16-bit parity, no padding
        mem_b[40] = 8'h12;
        mem_b[41] = 8'h34;
        b.I_start = 1'b1;
        step();
        chk("b_addr_e0", 32'(b.O_mem_addr), 40);
        b.I_start = 1'b0;
        step();
        chk("b_addr_e1", 32'(b.O_mem_addr), 41);
        step();
        chk("b_val_e2", 32'(b.O_valid), 0);
        step();
        chk("b_val_e3", 32'(b.O_valid), 1);
        chk("b_ecc_e3", 32'(b.O_ecc), 'h3412);

        // 20-bit parity, three words
        op_c(8'h01, 8'h02, 8'hFF, 'hF0201);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] w0, w1, w2;
            w0 = 8'($urandom);
            w1 = 8'($urandom);
            w2 = 8'($urandom);
            op_c(w0, w1, w2,
                 (int'(w2) * 65536 + int'(w1) * 256 + int'(w0)) % (1 << 20));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
